instruction_fetch_unit: RTL and testbench

INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

---
 rtl/instruction_fetch_unit_pkg.sv | 17 +
 rtl/instruction_fetch_unit.sv | 112 +++++++++++
 tb/tb_instruction_fetch_unit.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/instruction_fetch_unit_pkg.sv
// rtl/instruction_fetch_unit_pkg.sv - shared fetch FSM encoding, depth default and range helper
package instruction_fetch_unit_pkg;

  localparam int unsigned IFU_DEPTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_HALT  = 2'd3
  } ifu_state_e;

  function automatic logic in_range(input logic [31:0] addr, input logic [31:0] depth);
    return addr < depth;
  endfunction

endpackage

// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - word-indexed instruction fetcher with ready/valid output register
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter int unsigned DEPTH    = IFU_DEPTH,
  parameter logic [31:0] RESET_PC = 32'd0
) (
  input  logic        Clock,
  input  logic        Reset_n,
  input  logic        Start,
  input  logic [31:0] StartAddress,
  output logic [31:0] ReadAddress,
  input  logic [31:0] Instruction,
  output logic        InstrValid,
  input  logic        InstrReady,
  output logic [31:0] InstrOut,
  output logic [31:0] InstrPC,
  input  logic        Redirect,
  input  logic [31:0] RedirectAddress,
  output logic        Halted,
  output logic [31:0] FetchCount
);

  localparam logic [31:0] DEPTH_W = 32'(DEPTH);

  ifu_state_e  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        valid_q, valid_d;
  logic [31:0] out_q, out_d;
  logic [31:0] ipc_q, ipc_d;
  logic [31:0] count_q, count_d;
  logic        transfer;
  logic        reg_free;
  logic [31:0] pc_inc;

  assign transfer = valid_q & InstrReady;
  assign reg_free = ~valid_q | transfer;
  // pc_q < DEPTH whenever RUN captures, so this increment cannot wrap
  assign pc_inc   = pc_q + 32'd1;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    out_d   = out_q;
    ipc_d   = ipc_q;
    count_d = count_q;

    if (transfer && (count_q != 32'hFFFF_FFFF)) begin
      count_d = count_q + 32'd1;
    end

    case (state_q)
      ST_IDLE, ST_HALT: begin
        if (Start) begin
          pc_d    = StartAddress;
          valid_d = 1'b0;
          count_d = 32'd0;
          state_d = in_range(StartAddress, DEPTH_W) ? ST_RUN : ST_HALT;
        end
      end
      ST_RUN, ST_DRAIN: begin
        if (Redirect) begin
          // flush beats capture; a same-cycle transfer is still counted above
          valid_d = 1'b0;
          pc_d    = RedirectAddress;
          state_d = in_range(RedirectAddress, DEPTH_W) ? ST_RUN : ST_HALT;
        end else if (state_q == ST_RUN) begin
          if (reg_free) begin
            out_d   = Instruction;
            ipc_d   = pc_q;
            valid_d = 1'b1;
            pc_d    = pc_inc;
            if (pc_inc == DEPTH_W) begin
              state_d = ST_DRAIN;
            end
          end
        end else if (transfer) begin
          valid_d = 1'b0;
          state_d = ST_HALT;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
      valid_q <= 1'b0;
      out_q   <= 32'd0;
      ipc_q   <= 32'd0;
      count_q <= 32'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
      out_q   <= out_d;
      ipc_q   <= ipc_d;
      count_q <= count_d;
    end
  end

  assign ReadAddress = pc_q;
  assign InstrValid  = valid_q;
  assign InstrOut    = out_q;
  assign InstrPC     = ipc_q;
  assign Halted      = (state_q == ST_HALT);
  assign FetchCount  = count_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb/tb_instruction_fetch_unit.sv - vector table, directed corners and randomized model check
module tb_instruction_fetch_unit;

  localparam int D = 32;

  logic        Clock = 1'b0;
  logic        Reset_n;
  logic        Start;
  logic [31:0] StartAddress;
  logic [31:0] ReadAddress;
  logic [31:0] Instruction;
  logic        InstrValid;
  logic        InstrReady;
  logic [31:0] InstrOut;
  logic [31:0] InstrPC;
  logic        Redirect;
  logic [31:0] RedirectAddress;
  logic        Halted;
  logic [31:0] FetchCount;

  logic [31:0] mem [D];

  int n_cmp = 0;
  int n_err = 0;

  instruction_fetch_unit #(.DEPTH(D), .RESET_PC(32'd0)) dut (
    .Clock(Clock), .Reset_n(Reset_n), .Start(Start), .StartAddress(StartAddress),
    .ReadAddress(ReadAddress), .Instruction(Instruction), .InstrValid(InstrValid),
    .InstrReady(InstrReady), .InstrOut(InstrOut), .InstrPC(InstrPC),
    .Redirect(Redirect), .RedirectAddress(RedirectAddress), .Halted(Halted),
    .FetchCount(FetchCount)
  );

  always #5 Clock = ~Clock;

  always_comb begin
    if (ReadAddress < D) Instruction = mem[ReadAddress[4:0]];
    else                 Instruction = 32'hDEAD_BEEF;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic idle_inputs();
    Start = 0; StartAddress = 0; InstrReady = 0; Redirect = 0; RedirectAddress = 0;
  endtask

  task automatic do_reset();
    Reset_n = 0;
    #3;
    tick();
    Reset_n = 1;
  endtask

  // Behavioural reference: "active" means fetching or draining; draining is active with pc == D
  bit          m_active, m_halted, m_valid;
  logic [31:0] m_pc, m_out, m_ipc, m_cnt;

  task automatic model_reset();
    m_active = 0; m_halted = 0; m_valid = 0;
    m_pc = 0; m_out = 0; m_ipc = 0; m_cnt = 0;
  endtask

  task automatic model_step();
    bit xfer;
    xfer = m_valid && InstrReady;
    if (xfer && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
    if (!m_active) begin
      if (Start) begin
        m_cnt = 0; m_valid = 0; m_pc = StartAddress;
        m_halted = (StartAddress >= D);
        m_active = !m_halted;
      end
    end else if (Redirect) begin
      m_valid = 0; m_pc = RedirectAddress;
      if (RedirectAddress >= D) begin m_active = 0; m_halted = 1; end
    end else if (m_pc < D) begin
      if (!m_valid || xfer) begin
        m_out = mem[m_pc[4:0]]; m_ipc = m_pc; m_valid = 1; m_pc = m_pc + 1;
      end
    end else if (xfer) begin
      m_valid = 0; m_active = 0; m_halted = 1;
    end
  endtask

  typedef struct {
    logic        start;
    logic [31:0] saddr;
    logic        ready;
    logic        redir;
    logic [31:0] raddr;
    logic        e_valid;
    logic [31:0] e_ipc;
    logic [31:0] e_out;
    logic [31:0] e_ra;
    logic        e_halt;
    logic [31:0] e_cnt;
  } vec_t;

  vec_t vecs[$];

  initial begin
    int k;
    bit done;
    idle_inputs();
    for (int i = 0; i < D; i++) mem[i] = 32'h100 + i;

    Reset_n = 0;
    #2;
    chk("rst_ra", ReadAddress, 0);
    chk("rst_valid", {31'd0, InstrValid}, 0);
    chk("rst_out", InstrOut, 0);
    chk("rst_ipc", InstrPC, 0);
    chk("rst_halt", {31'd0, Halted}, 0);
    chk("rst_cnt", FetchCount, 0);
    tick();
    Reset_n = 1;

    // start, stream, stall, redirect, out-of-range, restart, drain with stall
    vecs.push_back('{1, 0, 1, 0, 0,   0, 0,  32'h000, 0,  0, 0});
    vecs.push_back('{0, 0, 1, 0, 0,   1, 0,  32'h100, 1,  0, 0});
    vecs.push_back('{0, 0, 1, 0, 0,   1, 1,  32'h101, 2,  0, 1});
    vecs.push_back('{0, 0, 0, 0, 0,   1, 1,  32'h101, 2,  0, 1});
    vecs.push_back('{0, 0, 0, 0, 0,   1, 1,  32'h101, 2,  0, 1});
    vecs.push_back('{0, 0, 1, 0, 0,   1, 2,  32'h102, 3,  0, 2});
    vecs.push_back('{0, 0, 1, 1, 20,  0, 2,  32'h102, 20, 0, 3});
    vecs.push_back('{0, 0, 1, 0, 0,   1, 20, 32'h114, 21, 0, 3});
    vecs.push_back('{0, 0, 0, 1, 40,  0, 20, 32'h114, 40, 1, 3});
    vecs.push_back('{0, 0, 1, 1, 5,   0, 20, 32'h114, 40, 1, 3});
    vecs.push_back('{1, 32, 1, 0, 0,  0, 20, 32'h114, 32, 1, 0});
    vecs.push_back('{1, 30, 1, 0, 0,  0, 20, 32'h114, 30, 0, 0});
    vecs.push_back('{0, 0, 1, 0, 0,   1, 30, 32'h11E, 31, 0, 0});
    vecs.push_back('{0, 0, 1, 0, 0,   1, 31, 32'h11F, 32, 0, 1});
    vecs.push_back('{0, 0, 0, 0, 0,   1, 31, 32'h11F, 32, 0, 1});
    vecs.push_back('{1, 0, 0, 0, 0,   1, 31, 32'h11F, 32, 0, 1});
    vecs.push_back('{0, 0, 1, 0, 0,   0, 31, 32'h11F, 32, 1, 2});

    foreach (vecs[i]) begin
      Start = vecs[i].start; StartAddress = vecs[i].saddr; InstrReady = vecs[i].ready;
      Redirect = vecs[i].redir; RedirectAddress = vecs[i].raddr;
      tick();
      chk($sformatf("v%0d_valid", i), {31'd0, InstrValid}, {31'd0, vecs[i].e_valid});
      chk($sformatf("v%0d_ipc", i), InstrPC, vecs[i].e_ipc);
      chk($sformatf("v%0d_out", i), InstrOut, vecs[i].e_out);
      chk($sformatf("v%0d_ra", i), ReadAddress, vecs[i].e_ra);
      chk($sformatf("v%0d_halt", i), {31'd0, Halted}, {31'd0, vecs[i].e_halt});
      chk($sformatf("v%0d_cnt", i), FetchCount, vecs[i].e_cnt);
    end
    idle_inputs();

    // full stream from 0 with the consumer always ready
    Start = 1; StartAddress = 0; InstrReady = 1;
    tick();
    Start = 0;
    k = 0; done = 0;
    for (int c = 0; c < 200 && !done; c++) begin
      if (InstrValid) begin
        chk("stream_ipc", InstrPC, k);
        chk("stream_out", InstrOut, 32'h100 + k);
        k++;
      end
      tick();
      if (Halted) done = 1;
    end
    chk("stream_done", {31'd0, done}, 1);
    chk("stream_xfers", k, 32);
    chk("stream_cnt", FetchCount, 32);
    chk("stream_valid", {31'd0, InstrValid}, 0);

    // asynchronous reset while InstrPC=10 is pending
    Start = 1; StartAddress = 0; InstrReady = 1;
    tick();
    Start = 0;
    done = 0;
    for (int c = 0; c < 50 && !done; c++) begin
      tick();
      if (InstrValid && InstrPC == 10) done = 1;
    end
    chk("midrst_reached", {31'd0, done}, 1);
    #2;
    Reset_n = 0;
    #1;
    chk("midrst_ra", ReadAddress, 0);
    chk("midrst_valid", {31'd0, InstrValid}, 0);
    chk("midrst_out", InstrOut, 0);
    chk("midrst_ipc", InstrPC, 0);
    chk("midrst_cnt", FetchCount, 0);
    tick();
    Reset_n = 1;
    InstrReady = 1; Redirect = 1; RedirectAddress = 4;
    for (int c = 0; c < 4; c++) tick();
    chk("idle_ra", ReadAddress, 0);
    chk("idle_valid", {31'd0, InstrValid}, 0);
    chk("idle_halt", {31'd0, Halted}, 0);
    chk("idle_cnt", FetchCount, 0);
    idle_inputs();

    // randomized run against the reference model
    for (int i = 0; i < D; i++) mem[i] = $urandom;
    do_reset();
    model_reset();
    for (int c = 0; c < 4000; c++) begin
      Start           = ($urandom % 12) == 0;
      StartAddress    = $urandom_range(0, 35);
      InstrReady      = ($urandom % 4) != 0;
      Redirect        = ($urandom % 16) == 0;
      RedirectAddress = $urandom_range(0, 40);
      model_step();
      tick();
      chk("rnd_ra", ReadAddress, m_pc);
      chk("rnd_valid", {31'd0, InstrValid}, {31'd0, m_valid});
      chk("rnd_out", InstrOut, m_out);
      chk("rnd_ipc", InstrPC, m_ipc);
      chk("rnd_halt", {31'd0, Halted}, {31'd0, m_halted});
      chk("rnd_cnt", FetchCount, m_cnt);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
